shift_reg_ctrl: RTL and testbench

Sequencing controller for the team's N-bit shift register built from DFFWR flip-flops. It accepts a frame request and issues a one-cycle parallel-load strobe. It then drives shift enables for a programmable bit count, with stall support, and signals completion. It sits between a requesting unit and the shift-register datapath. It owns no data bits itself.

---
 rtl/shift_reg_ctrl_if.sv | 28 ++
 rtl/shift_reg_ctrl.sv | 156 +++++++++++++++
 tb/tb_shift_reg_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_ctrl_if.sv
// Request/datapath bundle for shift_reg_ctrl.
// Handshake: start is a request, not a valid/ready pair. It is taken only on an
// edge where busy=0. While busy=1 a request is dropped, never queued, so a
// requester must wait for busy=0 and then hold start until the next edge.
interface shift_reg_ctrl_if #(
   parameter int CNT_W = 4
) ();
   logic             start;
   logic [CNT_W-1:0] len;
   logic             dir;
   logic             hold;
   logic             sr_load;
   logic             sr_shift;
   logic             sr_dir;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] bit_cnt;

   modport master (
      output start, len, dir, hold,
      input  sr_load, sr_shift, sr_dir, busy, done, bit_cnt
   );

   modport slave (
      input  start, len, dir, hold,
      output sr_load, sr_shift, sr_dir, busy, done, bit_cnt
   );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Load/shift/done sequencer for an external WIDTH-bit shift register.
// Optional macro SHIFT_CTRL_PRESCALE_EN: one shift every DIV unheld SHIFT cycles.
module shift_reg_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   shift_reg_ctrl_if.slave  bus,
   output logic [1:0]       state_dbg
);

   if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt_w
      $error("shift_reg_ctrl: CNT_W too narrow for WIDTH");
   end
   if (DIV < 2) begin : g_bad_div
      $error("shift_reg_ctrl: DIV must be at least 2");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

   state_t           state_q, state_d;
   logic             sr_load_q, sr_load_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sr_dir_q, sr_dir_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] len_eff;
   logic [CNT_W-1:0] bit_cnt_inc;
   logic             tick;
   logic             shift_en;

`ifdef SHIFT_CTRL_PRESCALE_EN
   localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

   logic [PRE_W-1:0] pre_q, pre_d;

   assign tick = (pre_q == PRE_W'(DIV - 1));

   // Held at zero outside SHIFT so every frame starts a fresh DIV window.
   always_comb begin
      pre_d = pre_q;
      if (state_q != S_SHIFT) begin
         pre_d = '0;
      end else if (!bus.hold) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   // A zero or oversized length both mean a full-register frame.
   always_comb begin
      len_eff = bus.len;
      if (bus.len == '0 || bus.len > LEN_MAX) begin
         len_eff = LEN_MAX;
      end
   end

   assign shift_en    = (state_q == S_SHIFT) & ~bus.hold & tick;
   assign bit_cnt_inc = bit_cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      sr_load_d = 1'b0;
      done_d    = 1'b0;
      busy_d    = busy_q;
      sr_dir_d  = sr_dir_q;
      len_d     = len_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               state_d   = S_LOAD;
               len_d     = len_eff;
               sr_dir_d  = bus.dir;
               sr_load_d = 1'b1;
               busy_d    = 1'b1;
               bit_cnt_d = '0;
            end
         end
         S_LOAD: begin
            state_d   = S_SHIFT;
            busy_d    = 1'b1;
            bit_cnt_d = '0;
         end
         S_SHIFT: begin
            busy_d = 1'b1;
            if (shift_en) begin
               bit_cnt_d = bit_cnt_inc;
               // The final shift and the DONE entry share one edge.
               if (bit_cnt_inc == len_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         sr_load_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sr_dir_q  <= 1'b0;
         bit_cnt_q <= '0;
         len_q     <= LEN_MAX;
      end else begin
         state_q   <= state_d;
         sr_load_q <= sr_load_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sr_dir_q  <= sr_dir_d;
         bit_cnt_q <= bit_cnt_d;
         len_q     <= len_d;
      end
   end

   assign bus.sr_load  = sr_load_q;
   assign bus.sr_shift = shift_en;
   assign bus.sr_dir   = sr_dir_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.bit_cnt  = bit_cnt_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl: frame timelines, length rules,
// stalls, busy collisions, mid-frame reset and (with the macro) prescaling.
module tb_shift_reg_ctrl;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
`ifdef SHIFT_CTRL_PRESCALE_EN
   localparam int TB_DIV = 4;
`else
   localparam int TB_DIV = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state_dbg;

   int checks   = 0;
   int failures = 0;

   // Packed as {sr_load, sr_shift, sr_dir, busy, done, bit_cnt}.
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   shift_reg_ctrl_if #(.CNT_W(CNT_W)) bus ();

   shift_reg_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .DIV   (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   function automatic logic [8:0] obs();
      return {bus.sr_load, bus.sr_shift, bus.sr_dir, bus.busy, bus.done, bus.bit_cnt};
   endfunction

   task automatic drive(input logic s, input logic [3:0] l, input logic d, input logic h);
      bus.start = s;
      bus.len   = l;
      bus.dir   = d;
      bus.hold  = h;
   endtask

   // Runs one frame starting in cycle 0. Expected outputs come from a timeline:
   // shift cycles are placed first, then every cycle's outputs follow from them.
   task automatic run_frame(input string name, input int len_in, input logic d,
                            input int hold_lo, input int hold_hi, input int coll);
      bit         act[0:127];
      int         l_eff, shifts, k, c, done_c, cnt;
      logic [8:0] e, got;
      l_eff = (len_in == 0 || len_in > WIDTH) ? WIDTH : len_in;
      foreach (act[i]) act[i] = 1'b0;
      shifts = 0;
      k      = 0;
      c      = 2;
      while (shifts < l_eff && c < 120) begin
         if (!(c >= hold_lo && c <= hold_hi)) begin
            k++;
            if (k % TB_DIV == 0) begin
               act[c] = 1'b1;
               shifts++;
            end
         end
         c++;
      end
      done_c = c;
      cnt    = 0;
      for (int cy = 0; cy <= done_c + 1; cy++) begin
         drive((cy == 0) || (cy == coll), (cy == 0) ? 4'(len_in) : 4'd3,
               (cy == 0) ? d : 1'b1, (cy >= hold_lo && cy <= hold_hi));
         if (cy >= 1) begin
            e = {cy == 1, act[cy] && (cy < done_c), d, cy <= done_c, cy == done_c,
                 (cy >= done_c) ? 4'(l_eff) : 4'(cnt)};
            exp_q.push_back(e);
         end
         @(negedge clk);
         if (cy >= 1) begin
            got = obs();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
               failures++;
               $display("FAIL %s cycle=%0d got{load,shift,dir,busy,done,cnt}=%b expected=%b",
                        name, cy, got, e);
            end
            if (act[cy]) cnt++;
         end
         @(posedge clk);
         #1;
      end
      drive(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         checks++;
         if (obs() !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=%b", obs(), 9'd0);
         end
         checks++;
         if (state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d expected=0", state_dbg);
         end
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      run_frame("basic_len8", 8, 1'b0, -1, -2, -1);
   endtask

   task automatic test_length();
      run_frame("len3_right", 3, 1'b1, -1, -2, -1);
      run_frame("len0_full", 0, 1'b0, -1, -2, -1);
      run_frame("len12_clamp", 12, 1'b1, -1, -2, -1);
   endtask

   task automatic test_stall();
      run_frame("stall_4_6", 8, 1'b0, 4, 6, -1);
   endtask

   task automatic test_collision();
      run_frame("busy_collision", 8, 1'b0, -1, -2, 5);
   endtask

   task automatic test_back_to_back();
      run_frame("b2b_len1", 1, 1'b1, -1, -2, -1);
      run_frame("b2b_len2_hold_in_load", 2, 1'b0, 1, 1, -1);
   endtask

   task automatic test_mid_reset();
      int   rst_cy;
      logic done_seen;
      rst_cy = 2 + 4 * TB_DIV;
      for (int cy = 0; cy <= rst_cy; cy++) begin
         drive(cy == 0, 4'd8, 1'b1, 1'b0);
         if (cy == rst_cy) rst = 1'b0;
         @(negedge clk);
         if (cy == rst_cy) begin
            checks++;
            if (bus.bit_cnt !== 4'd4) begin
               failures++;
               $display("FAIL mid_reset_precount got=%0d expected=4", bus.bit_cnt);
            end
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (obs() !== 9'd0 || state_dbg !== 2'd0) begin
         failures++;
         $display("FAIL mid_reset_outputs got=%b state=%0d expected=%b state=0",
                  obs(), state_dbg, 9'd0);
      end
      done_seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         done_seen = done_seen | bus.done;
      end
      checks++;
      if (done_seen !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_no_done got=%b expected=0", done_seen);
      end
      @(posedge clk);
      #1;
      run_frame("post_reset_len2", 2, 1'b0, -1, -2, -1);
   endtask

`ifdef SHIFT_CTRL_PRESCALE_EN
   task automatic test_prescale();
      run_frame("prescale_len8", 8, 1'b0, -1, -2, -1);
      run_frame("prescale_stall", 3, 1'b1, 6, 8, -1);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_length();
      test_stall();
      test_collision();
      test_back_to_back();
      test_mid_reset();
`ifdef SHIFT_CTRL_PRESCALE_EN
      test_prescale();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
